// File: rtl/c16_reset_seq.sv
// Reset sequencer: filtered, maskable requests, staggered channel release, sticky cause (watchdog under RST_WDOG_EN).
// Request edge to all-asserted is FILT_LEN+1 cycles; channel k releases HOLD_CYCLES+1+k*STAGGER after the last trigger; no backpressure.
module c16_reset_seq #(
  parameter int NSRC        = 2,
  parameter int NCH         = 3,
  parameter int CNT_W       = 24,
  parameter int HOLD_CYCLES = 16777215,
  parameter int STAGGER     = 1024,
  parameter int FILT_LEN    = 4,
  parameter int WDOG_CYCLES = 28375168
) (
  input  logic            clk28_i,
  input  logic            reset_i,
  input  logic [NSRC-1:0] req_i,
  input  logic [NSRC-1:0] req_mask_i,
  input  logic            cause_clr_i,
  input  logic            wdog_kick_i,
  output logic [NCH-1:0]  rst_out_o,
  output logic            busy_o,
  output logic [NSRC+1:0] cause_o
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  if (NSRC < 1 || NCH < 1) begin : g_bad_width
    $error("c16_reset_seq: NSRC and NCH must be at least 1");
  end
  if (HOLD_CYCLES < 1 || longint'(HOLD_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_hold
    $error("c16_reset_seq: HOLD_CYCLES must be in 1..2^CNT_W-1");
  end
  if (STAGGER < 1 || longint'(STAGGER) > (longint'(1) << CNT_W) - 1) begin : g_bad_stagger
    $error("c16_reset_seq: STAGGER must be in 1..2^CNT_W-1");
  end
  if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt
    $error("c16_reset_seq: FILT_LEN must be in 1..15");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("c16_reset_seq: WDOG_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_RELEASE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CH_W-1:0]   ch_q;
  logic [NCH-1:0]    rst_q;
  logic              busy_q;
  logic [NSRC+1:0]   cause_q;

  logic [NSRC-1:0][3:0] filt_q, filt_d;
  logic [NSRC-1:0]      trig_q, trig_d;
  logic [NSRC-1:0]      req_act;
  logic                 wdog_fire;
  logic [NSRC+1:0]      trig_all;
  logic                 any_trig;
  logic [CNT_W-1:0]     rel_tgt;

  assign req_act = req_i & ~req_mask_i;

  // trig_d fires on the step into FILT_LEN, so a held request cannot retrigger
  always_comb begin
    filt_d = filt_q;
    trig_d = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (!req_act[i]) begin
        filt_d[i] = '0;
      end else if (filt_q[i] != 4'(FILT_LEN)) begin
        filt_d[i] = filt_q[i] + 4'd1;
        trig_d[i] = (filt_q[i] == 4'(FILT_LEN - 1));
      end
    end
  end

  always_ff @(posedge clk28_i) begin
    if (reset_i) begin
      filt_q <= '0;
      trig_q <= '0;
    end else begin
      filt_q <= filt_d;
      trig_q <= trig_d;
    end
  end

`ifdef RST_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q;

  assign wdog_fire = (state_q == ST_IDLE) && (wdog_q == WD_W'(WDOG_CYCLES - 1)) && !wdog_kick_i;

  always_ff @(posedge clk28_i) begin
    if (reset_i || wdog_kick_i || (state_q != ST_IDLE) || wdog_fire) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + WD_W'(1);
    end
  end
`else
  logic unused_wdog_kick;
  assign unused_wdog_kick = wdog_kick_i;
  assign wdog_fire        = 1'b0;
`endif

  assign trig_all = {wdog_fire, trig_q, 1'b0};
  assign any_trig = |trig_all;

  // Channel 0 drops the cycle after RELEASE entry; later channels wait a full STAGGER
  assign rel_tgt = (ch_q == '0) ? '0 : CNT_W'(STAGGER - 1);

  always_ff @(posedge clk28_i) begin
    if (reset_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      ch_q    <= '0;
      rst_q   <= '1;
      busy_q  <= 1'b1;
      cause_q <= {{(NSRC+1){1'b0}}, 1'b1};
    end else begin
      cause_q <= (cause_clr_i ? '0 : cause_q) | trig_all;
      if (any_trig) begin
        state_q <= ST_ASSERT;
        cnt_q   <= '0;
        ch_q    <= '0;
        rst_q   <= '1;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            rst_q  <= '0;
            busy_q <= 1'b0;
          end
          ST_ASSERT: begin
            if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
              state_q <= ST_RELEASE;
              cnt_q   <= '0;
              ch_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_RELEASE: begin
            if (cnt_q == rel_tgt) begin
              rst_q[ch_q] <= 1'b0;
              cnt_q       <= '0;
              if (ch_q == CH_W'(NCH - 1)) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                ch_q <= ch_q + CH_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            rst_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rst_out_o = rst_q;
  assign busy_o    = busy_q;
  assign cause_o   = cause_q;

endmodule

// File: tb/tb_c16_reset_seq.sv
// Bench for c16_reset_seq: directed steps then randomized traffic, checked against a time-since-last-trigger model.
module tb_c16_reset_seq;
  localparam int NSRC  = 2;
  localparam int NCH   = 3;
  localparam int CNT_W = 8;
  localparam int HOLD  = 16;
  localparam int STAG  = 4;
  localparam int FILT  = 3;
  localparam int WDOG  = 50;
  localparam int LAST  = HOLD + 1 + (NCH - 1) * STAG;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] mask;
  logic            clr;
  logic            kick;
  logic [NCH-1:0]  rst_out_o;
  logic            busy_o;
  logic [NSRC+1:0] cause_o;

  c16_reset_seq #(
    .NSRC(NSRC), .NCH(NCH), .CNT_W(CNT_W), .HOLD_CYCLES(HOLD),
    .STAGGER(STAG), .FILT_LEN(FILT), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk28_i(clk), .reset_i(reset), .req_i(req), .req_mask_i(mask),
    .cause_clr_i(clr), .wdog_kick_i(kick),
    .rst_out_o(rst_out_o), .busy_o(busy_o), .cause_o(cause_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: every output follows from the edge index of the most recent trigger.
  int              cyc    = 0;
  int              t_last = 0;
  int              wd     = 0;
  int              run  [NSRC];
  bit              pend [NSRC];
  logic [NSRC+1:0] m_cause = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH-1:0] exp_rst();
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) r[k] = ((cyc - t_last) < (HOLD + 1 + k * STAG));
    return r;
  endfunction

  task automatic model_edge();
    logic [NSRC+1:0] bits;
    bit              idle_pre;
    cyc++;
    if (reset) begin
      t_last  = cyc;
      m_cause = 1;
      wd      = 0;
      for (int i = 0; i < NSRC; i++) begin
        run[i]  = 0;
        pend[i] = 0;
      end
    end else begin
      idle_pre = ((cyc - 1 - t_last) >= LAST);
      bits = '0;
      for (int i = 0; i < NSRC; i++) begin
        bits[i+1] = pend[i];
        run[i]    = (req[i] && !mask[i]) ? run[i] + 1 : 0;
        pend[i]   = (run[i] == FILT);
      end
`ifdef RST_WDOG_EN
      if (!idle_pre || kick) wd = 0;
      else if (wd == WDOG - 1) begin
        bits[NSRC+1] = 1'b1;
        wd = 0;
      end else wd++;
`else
      if (idle_pre) wd = 0;
`endif
      if (clr) m_cause = '0;
      if (bits != '0) begin
        t_last  = cyc;
        m_cause = m_cause | bits;
      end
    end
  endtask

  task automatic tick();
    logic [NCH-1:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_rst();
    chk("rst_out", rst_out_o, e);
    chk("busy", busy_o, e[NCH-1]);
    chk("cause", cause_o, m_cause);
  endtask

  initial begin
    int n;
    int busy_seen;
    reset = 1'b1; req = '0; mask = '0; clr = 1'b0; kick = 1'b0;
    tick();
    chk("reset_rst", rst_out_o, 3'b111);
    chk("reset_busy", busy_o, 1'b1);
    chk("reset_cause", cause_o, 4'b0001);
    reset = 1'b0;

    // 1: hard reset release timeline
    repeat (16) tick();
    chk("t1_hold_end", rst_out_o, 3'b111);
    tick();
    chk("t1_ch0", rst_out_o, 3'b110);
    repeat (4) tick();
    chk("t1_ch1", rst_out_o, 3'b100);
    repeat (3) tick();
    chk("t1_busy_before_last", busy_o, 1'b1);
    tick();
    chk("t1_ch2", rst_out_o, 3'b000);
    chk("t1_busy_fall", busy_o, 1'b0);
    chk("t1_cause", cause_o, 4'b0001);

    // 2: filter length
    req = 2'b01; repeat (2) tick(); req = 2'b00;
    repeat (4) tick();
    chk("t2_short_pulse", rst_out_o, 3'b000);
    req = 2'b01; repeat (3) tick(); req = 2'b00;
    chk("t2_before_fire", rst_out_o, 3'b000);
    tick();
    chk("t2_fire", rst_out_o, 3'b111);
    chk("t2_cause", cause_o, 4'b0011);

    // 3: trigger mid-release restarts the whole sequence
    repeat (17) tick();
    chk("t3_ch0_low", rst_out_o, 3'b110);
    tick();
    req = 2'b10; repeat (3) tick(); req = 2'b00;
    chk("t3_mid_release", rst_out_o, 3'b100);
    tick();
    chk("t3_restart", rst_out_o, 3'b111);
    chk("t3_cause", cause_o, 4'b0111);
    n = 0;
    while (rst_out_o !== 3'b000 && n < 60) begin tick(); n++; end
    chk("t3_restart_len", n, LAST);

    // 4: masking, then clear colliding with a trigger
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t4_clr", cause_o, 4'b0000);
    mask = 2'b01; req = 2'b11; repeat (10) tick(); req = 2'b00; mask = 2'b00;
    chk("t4_masked_cause", cause_o, 4'b0100);
    n = 0;
    while (busy_o !== 1'b0 && n < 60) begin tick(); n++; end
    chk("t4_idle", busy_o, 1'b0);
    req = 2'b01; repeat (3) tick(); req = 2'b00;
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t4_clr_vs_trig", cause_o, 4'b0010);
    chk("t4_clr_vs_trig_rst", rst_out_o, 3'b111);

    // 5: simultaneous requests
    n = 0;
    while (busy_o !== 1'b0 && n < 60) begin tick(); n++; end
    clr = 1'b1; tick(); clr = 1'b0;
    req = 2'b11; repeat (3) tick(); req = 2'b00;
    tick();
    chk("t5_rst", rst_out_o, 3'b111);
    chk("t5_cause", cause_o, 4'b0110);
    n = 0;
    while (rst_out_o !== 3'b000 && n < 60) begin tick(); n++; end
    chk("t5_single_restart_len", n, LAST);

    // 6: watchdog
`ifdef RST_WDOG_EN
    n = 0;
    while (busy_o !== 1'b1 && n < 80) begin tick(); n++; end
    chk("t6_wdog_len", n, WDOG);
    chk("t6_wdog_cause", cause_o[NSRC+1], 1'b1);
    n = 0;
    while (busy_o !== 1'b0 && n < 60) begin tick(); n++; end
`else
    repeat (60) tick();
    chk("t6_no_wdog_cause", cause_o[NSRC+1], 1'b0);
`endif
    busy_seen = 0;
    for (int j = 0; j < 160; j++) begin
      kick = ((j % 40) == 39);
      tick();
      if (busy_o !== 1'b0) busy_seen++;
    end
    kick = 1'b0;
    chk("t6_kicked_no_reset", busy_seen, 0);

    // Randomized traffic: alternating noisy and quiet windows
    for (int j = 0; j < 1200; j++) begin
      if (((j / 100) % 2) == 0) begin
        for (int i = 0; i < NSRC; i++) begin
          if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
          if ($urandom_range(0, 19) == 0) mask[i] = ~mask[i];
        end
      end else begin
        req  = '0;
        mask = '0;
      end
      clr   = ($urandom_range(0, 19) == 0);
      kick  = ($urandom_range(0, 29) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; req = '0; mask = '0; clr = 1'b0; kick = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
